// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter with scan-out fetch slots, 4-entry write FIFO and clear-screen fill
module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        posx,
    input  logic [9:0]        posy,
    input  logic              active,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              ovr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb
);
    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);
    state_t state;
    logic [ADDR_W-1:0] q_addr [4];
    logic [DATA_W-1:0] q_data [4];
    logic [3:0] q_ok;
    logic [1:0] wp, rp;
    logic [2:0] cnt, cnt_n;
    logic [ADDR_W-1:0] clr_cnt, addr_q;
    logic [DATA_W-1:0] clr_col, wdata_q, cell_reg;
    logic rst_done, fetch, fetch_d1, act_d1, act_d2, push, pop, clr_wr, clr_last, full, empty, in_rng;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] cx, input logic [7:0] cy);
        return ADDR_W'({cy, 7'd0}) + ADDR_W'({cy, 5'd0}) + ADDR_W'(cx);
    endfunction

    assign fetch     = active && posx[1:0] == 2'd0;
    assign full      = cnt == 3'd4;
    assign empty     = cnt == 3'd0;
    assign in_rng    = 32'(wr_x) < FB_W && 32'(wr_y) < FB_H;
    assign wr_ready  = rst_done && !full && state == RUN;
    assign push      = wr_valid && wr_ready;
    assign pop       = !fetch && !empty && state != CLEAR;
    assign clr_wr    = !fetch && state == CLEAR;
    assign clr_last  = clr_cnt == CLR_LAST;
    assign cnt_n     = cnt + 3'(push) - 3'(pop);
    assign mem_we    = (pop && q_ok[rp]) || clr_wr;
    assign mem_addr  = fetch ? cell_addr(posx[9:2], posy[9:2]) : mem_we ? (clr_wr ? clr_cnt : q_addr[rp]) : addr_q;
    assign mem_wdata = mem_we ? (clr_wr ? clr_col : q_data[rp]) : wdata_q;
    assign clr_busy  = state != RUN;
    assign rgb       = act_d2 ? cell_reg : '0;

    // FIFO payload needs no reset; occupancy and pointers carry validity
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wp] <= cell_addr(wr_x, {1'b0, wr_y});
            q_data[wp] <= wr_data;
            q_ok[wp]   <= in_rng;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            clr_cnt  <= '0;
            clr_col  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cell_reg <= '0;
            fetch_d1 <= 1'b0;
            act_d1   <= 1'b0;
            act_d2   <= 1'b0;
            ovr_err  <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            fetch_d1 <= fetch;
            act_d1   <= active;
            act_d2   <= act_d1;
            cnt      <= cnt_n;
            if (fetch_d1) cell_reg <= mem_rdata;
            if (push) wp <= wp + 2'd1;
            if (pop) rp <= rp + 2'd1;
            if (push && !in_rng) ovr_err <= 1'b1;
            case (state)
                RUN: if (clr_req) begin
                    clr_col <= clr_color;
                    state   <= cnt_n != 3'd0 ? DRAIN : CLEAR;
                end
                DRAIN: if (empty) state <= CLEAR;
                CLEAR: if (clr_wr) begin
                    clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
                    if (clr_last) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of fetch slots, write FIFO, overrange flag and clear fill
module tb_vga_fb_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic [9:0] posx = '0, posy = '0;
    logic active = 1'b0, wr_valid = 1'b0, clr_req = 1'b0;
    logic [7:0] wr_x = '0, wr_data = '0, clr_color = '0;
    logic [6:0] wr_y = '0;
    logic wr_ready, clr_busy, ovr_err, mem_we;
    logic [14:0] mem_addr;
    logic [7:0] mem_wdata, rgb;
    logic [7:0] mem_rdata = '0;
    logic [7:0] ram [19200];
    logic [14:0] wlog [$];
    logic [7:0] dlog [$];
    int we_in_fetch = 0;
    int tests = 0, fails = 0;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .posx(posx), .posy(posy), .active(active),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy), .ovr_err(ovr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM plus a log of every committed write
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (!rst && mem_we) begin
            ram[mem_addr] = mem_wdata;
            wlog.push_back(mem_addr);
            dlog.push_back(mem_wdata);
            if (active && posx[1:0] == 2'd0) we_in_fetch++;
        end
    end

    task automatic scan_row(input int y, input int x0, input int x1, input int hot,
                            input logic [7:0] hot_v, input logic [7:0] base_v, input string tag);
        logic [7:0] e;
        repeat (2) begin
            @(negedge clk); active = 1'b0; posx = 10'(x0); posy = 10'(y);
        end
        for (int p = x0; p <= x1 + 2; p++) begin
            @(negedge clk); posx = 10'(p); posy = 10'(y); active = p <= x1; #1;
            e = p < x0 + 2 ? 8'h00 : (((p - 2) >> 2) == hot ? hot_v : base_v);
            tests++; if (rgb !== e) begin fails++; $display("FAIL %s posx=%0d: rgb got %h expected %h", tag, p, rgb, e); end
        end
        @(negedge clk); active = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_held: got %b expected 0", wr_ready); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        tests++; if (rgb !== 8'h00) begin fails++; $display("FAIL reset_rgb: got %h expected 00", rgb); end
        tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        tests++; if (ovr_err !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b expected 0", ovr_err); end
        tests++; if (mem_addr !== 15'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    endtask

    task automatic test_write_blank();
        @(negedge clk); posx = 10'd0; posy = 10'd490; active = 1'b0;
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 8'hE0; #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL wb_ready: got %b expected 1", wr_ready); end
        @(negedge clk); wr_valid = 1'b0; #1;
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL wb_we: got %b expected 1", mem_we); end
        tests++; if (mem_addr !== 15'd485) begin fails++; $display("FAIL wb_addr: got %0d expected 485", mem_addr); end
        tests++; if (mem_wdata !== 8'hE0) begin fails++; $display("FAIL wb_data: got %h expected e0", mem_wdata); end
        @(negedge clk); #1;
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL idle_we: got %b expected 0", mem_we); end
        tests++; if (mem_addr !== 15'd485) begin fails++; $display("FAIL idle_addr: got %0d expected 485", mem_addr); end
        tests++; if (mem_wdata !== 8'hE0) begin fails++; $display("FAIL idle_data: got %h expected e0", mem_wdata); end
    endtask

    task automatic test_display();
        scan_row(12, 16, 27, 5, 8'hE0, 8'h00, "disp_r12");
        scan_row(15, 16, 27, 5, 8'hE0, 8'h00, "disp_r15");
        scan_row(11, 16, 27, -1, 8'h00, 8'h00, "disp_r11");
    endtask

    task automatic test_ovr();
        wlog.delete(); dlog.delete();
        @(negedge clk); posx = 10'd0; posy = 10'd490; active = 1'b0;
        wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_data = 8'h77; #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL ovr_ready: got %b expected 1", wr_ready); end
        @(negedge clk); wr_valid = 1'b0; #1;
        tests++; if (ovr_err !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", ovr_err); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL ovr_we: got %b expected 0", mem_we); end
        repeat (4) @(negedge clk);
        #1;
        tests++; if (ovr_err !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", ovr_err); end
        tests++; if (wlog.size() !== 0) begin fails++; $display("FAIL ovr_nowrite: got %0d writes expected 0", wlog.size()); end
    endtask

    task automatic test_burst();
        int idx = 0;
        wlog.delete(); dlog.delete(); we_in_fetch = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            posx = cyc < 6 ? 10'd0 : 10'(cyc - 5); posy = 10'd0; active = 1'b1;
            wr_valid = idx < 6; wr_x = 8'(10 + idx); wr_y = 7'd20; wr_data = 8'(8'h40 + idx); #1;
            if (cyc == 4) begin
                tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL burst_full_ready: got %b expected 0", wr_ready); end
                tests++; if (idx !== 4) begin fails++; $display("FAIL burst_accepted: got %0d expected 4", idx); end
            end
            if (cyc == 6) begin
                tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL burst_full_pop_ready: got %b expected 0", wr_ready); end
                tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL burst_first_pop: got %b expected 1", mem_we); end
            end
            if (wr_valid && wr_ready) idx++;
        end
        wr_valid = 1'b0; active = 1'b0;
        tests++; if (we_in_fetch !== 0) begin fails++; $display("FAIL burst_fetch_collision: got %0d expected 0", we_in_fetch); end
        tests++;
        if (wlog.size() !== 6) begin
            fails++; $display("FAIL burst_count: got %0d writes expected 6", wlog.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (wlog[i] !== 15'(3210 + i) || dlog[i] !== 8'(8'h40 + i)) begin
                    fails++; $display("FAIL burst_order[%0d]: got %0d/%h expected %0d/%h", i, wlog[i], dlog[i], 3210 + i, 8'h40 + i);
                    break;
                end
        end
    endtask

    task automatic test_clear();
        bit done = 0, prev_last = 0;
        int bad = 0;
        wlog.delete(); dlog.delete();
        @(negedge clk); posx = 10'd0; posy = 10'd0; active = 1'b1;
        wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd1; wr_data = 8'h11;
        @(negedge clk); wr_x = 8'd2; wr_data = 8'h22;
        @(negedge clk); wr_valid = 1'b0; clr_req = 1'b1; clr_color = 8'h1C;
        @(negedge clk); clr_req = 1'b0; active = 1'b0; posy = 10'd490; #1;
        tests++; if (clr_busy !== 1'b1) begin fails++; $display("FAIL clr_busy_rise: got %b expected 1", clr_busy); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL clr_ready_low: got %b expected 0", wr_ready); end
        tests++; if (mem_addr !== 15'd161) begin fails++; $display("FAIL drain_addr: got %0d expected 161", mem_addr); end
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk); clr_req = i == 100; if (i == 100) clr_color = 8'hFF; #1;
            if (!clr_busy) done = 1;
            else prev_last = mem_we && mem_addr == 15'd19199;
        end
        clr_req = 1'b0;
        tests++; if (!done) begin fails++; $display("FAIL clr_timeout: busy got %b expected 0", clr_busy); end
        tests++; if (prev_last !== 1'b1) begin fails++; $display("FAIL clr_busy_fall: last write flag got %b expected 1", prev_last); end
        tests++;
        if (wlog.size() !== 19202) begin
            fails++; $display("FAIL clr_count: got %0d writes expected 19202", wlog.size());
        end else begin
            if (wlog[0] !== 15'd161 || dlog[0] !== 8'h11 || wlog[1] !== 15'd162 || dlog[1] !== 8'h22) bad++;
            for (int k = 0; k < 19200; k++) if (wlog[k + 2] !== 15'(k) || dlog[k + 2] !== 8'h1C) bad++;
            if (bad != 0) begin fails++; $display("FAIL clr_order: got %0d bad writes expected 0", bad); end
        end
        bad = 0;
        for (int k = 0; k < 19200; k++) if (ram[k] !== 8'h1C) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL clr_ram: got %0d cells not 1c expected 0", bad); end
        scan_row(0, 0, 15, -1, 8'h00, 8'h1C, "clr_top");
        scan_row(479, 624, 639, -1, 8'h00, 8'h1C, "clr_bottom");
    endtask

    task automatic test_reset_mid_clear();
        bit found = 0;
        @(negedge clk); posx = 10'd0; posy = 10'd490; active = 1'b0; clr_req = 1'b1; clr_color = 8'h03;
        @(negedge clk); clr_req = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk); #1;
            if (mem_we && mem_addr == 15'd5000) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rmc_reach: write to 5000 got %b expected 1", found); end
        rst = 1'b1; #1;
        tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL rmc_busy_async: got %b expected 0", clr_busy); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL rmc_ready_held: got %b expected 0", wr_ready); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL rmc_busy: got %b expected 0", clr_busy); end
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rmc_ready: got %b expected 1", wr_ready); end
        wlog.delete(); dlog.delete();
        repeat (50) @(negedge clk);
        tests++; if (wlog.size() !== 0) begin fails++; $display("FAIL rmc_nowrite: got %0d writes expected 0", wlog.size()); end
        tests++; if (ram[4999] !== 8'h03) begin fails++; $display("FAIL rmc_ram4999: got %h expected 03", ram[4999]); end
        tests++; if (ram[5000] !== 8'h1C) begin fails++; $display("FAIL rmc_ram5000: got %h expected 1c", ram[5000]); end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) ram[i] = 8'h00;
        test_reset();
        test_write_blank();
        test_display();
        test_ovr();
        test_burst();
        test_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
